// File: rtl/cla_pkg.sv
// cla_pkg: shared lookahead constants, result type and the 4-wide carry-lookahead function
//   GRP_W         : bits (or groups) resolved by one lookahead block
//   la_t          : carries into each position plus block generate/propagate
//   cla_lookahead : flattened 4-wide lookahead, used per bit group and per group chunk
package cla_pkg;
   localparam int GRP_W = 4;
   typedef logic [GRP_W-1:0] grp_t;
   typedef struct packed {
      grp_t c;
      logic gm;
      logic pm;
   } la_t;
   function automatic la_t cla_lookahead(input grp_t p, input grp_t g, input logic c0);
      la_t r;
      r.c[0] = c0;
      r.c[1] = g[0] | (p[0] & c0);
      r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      r.gm   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.pm   = &p;
      return r;
   endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: 4-bit lookahead group
//   a, b : operand bits (b already inverted for subtract)
//   c0   : carry into the group
//   s    : group sum
//   gm   : group generate, pm : group propagate (both independent of c0)
module cla_group4 import cla_pkg::*; (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       gm,
   output logic       pm
);
   logic [3:0] p, g;
   la_t la;
   assign p  = a ^ b;
   assign g  = a & b;
   assign la = cla_lookahead(p, g, c0);
   assign s  = p ^ la.c;
   assign gm = la.gm;
   assign pm = la.pm;
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready handshake
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   sub, cin, x, y       : operation select, carry-in (add only), operands
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out of MSB (1 = no borrow on subtract), signed overflow
module cla_pipe_adder import cla_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int GPS   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int LW = GRP_W * GPS;
   localparam int NS = WIDTH / LW;
   localparam int NC = (GPS + GRP_W - 1) / GRP_W;
   logic             en;
   logic [WIDTH-1:0] yi;
   logic             c_first;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;
   // y is inverted once at entry so the skewed operand slices already carry the subtract
   assign yi      = sub ? ~y : y;
   assign c_first = sub | cin;
   genvar k, q, n, j;
   for (k = 0; k < NS; k++) begin : stg
      logic [LW-1:0]  a, b, s;
      logic [GPS-1:0] gmv, pmv;
      logic           vi, ci, co, v, c;
      logic [LW-1:0]  sq [NS-k];
      if (k == 0) begin : src
         assign a  = x[LW-1:0];
         assign b  = yi[LW-1:0];
         assign vi = in_valid;
         assign ci = c_first;
      end else begin : src
         // slice k waits k register levels so it meets the carry of its own beat
         logic [LW-1:0] xq [k];
         logic [LW-1:0] yq [k];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int m = 0; m < k; m++) begin
                  xq[m] <= '0;
                  yq[m] <= '0;
               end
            end else if (en) begin
               xq[0] <= x[k*LW +: LW];
               yq[0] <= yi[k*LW +: LW];
               for (int m = 1; m < k; m++) begin
                  xq[m] <= xq[m-1];
                  yq[m] <= yq[m-1];
               end
            end
         end
         assign a  = xq[k-1];
         assign b  = yq[k-1];
         assign vi = stg[k-1].v;
         assign ci = stg[k-1].c;
      end
      // second-level lookahead over the groups, four at a time; missing groups pad as pure propagate
      for (q = 0; q < NC; q++) begin : chk
         grp_t pp, gg;
         la_t  la;
         logic cq, co_q;
         for (n = 0; n < GRP_W; n++) begin : pad
            if (q*GRP_W + n < GPS) begin : used
               assign pp[n] = pmv[q*GRP_W + n];
               assign gg[n] = gmv[q*GRP_W + n];
            end else begin : used
               assign pp[n] = 1'b1;
               assign gg[n] = 1'b0;
            end
         end
         if (q == 0) begin : cin_sel
            assign cq = ci;
         end else begin : cin_sel
            assign cq = chk[q-1].co_q;
         end
         assign la   = cla_lookahead(pp, gg, cq);
         assign co_q = la.gm | (la.pm & cq);
      end
      assign co = chk[NC-1].co_q;
      for (j = 0; j < GPS; j++) begin : grp
         cla_group4 u_grp (
            .a (a[j*GRP_W +: GRP_W]),
            .b (b[j*GRP_W +: GRP_W]),
            .c0(chk[j/GRP_W].la.c[j%GRP_W]),
            .s (s[j*GRP_W +: GRP_W]),
            .gm(gmv[j]),
            .pm(pmv[j])
         );
      end
      // completed slice k rides NS-k registers so every slice of a beat leaves together
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v <= 1'b0;
            c <= 1'b0;
            for (int m = 0; m < NS-k; m++) sq[m] <= '0;
         end else if (en) begin
            v     <= vi;
            c     <= co;
            sq[0] <= s;
            for (int m = 1; m < NS-k; m++) sq[m] <= sq[m-1];
         end
      end
      assign sum[k*LW +: LW] = sq[NS-k-1];
      if (k == NS-1) begin : fin
         logic ovf_q;
         // carry into the MSB is recovered from its propagate and sum bits
         always_ff @(posedge clk or posedge rst) begin
            if (rst) ovf_q <= 1'b0;
            else if (en) ovf_q <= a[LW-1] ^ b[LW-1] ^ s[LW-1] ^ co;
         end
      end
   end
   assign out_valid = stg[NS-1].v;
   assign cout      = stg[NS-1].c;
   assign ovf       = stg[NS-1].fin.ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed vectors, streaming, backpressure and reset checks for both configurations
module tb_cla_pipe_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
   logic [63:0] x, y, sum;
   logic        in_valid2, in_ready2, sub2, cin2, out_valid2, out_ready2, cout2, ovf2;
   logic [31:0] x2, y2, sum2;
   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(64), .GPS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub), .cin(cin),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );
   cla_pipe_adder #(.WIDTH(32), .GPS(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .sub(sub2), .cin(cin2),
      .x(x2), .y(y2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   typedef struct {
      logic [63:0] x, y;
      logic        sub, cin;
      logic [63:0] s;
      logic        co, ov;
   } vec_t;
   vec_t tbl [12];
   int total = 0, bad = 0, lat;
   logic [65:0] q [$], q2 [$];
   logic sb_on = 1'b0, sb2_on = 1'b0;
   logic hold_prev = 1'b0, hold2_prev = 1'b0;
   logic [64:0] hold_val;
   logic [32:0] hold2_val;

   task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // returns {cout, ovf, sum} of an n-bit add/subtract
   function automatic logic [65:0] model(input int n, input logic [63:0] a, input logic [63:0] b, input logic s, input logic c);
      logic [64:0] m, aa, bb, r;
      logic        ov;
      m  = (65'd1 << n) - 65'd1;
      aa = {1'b0, a} & m;
      bb = {1'b0, s ? ~b : b} & m;
      r  = aa + bb + {64'd0, s | c};
      ov = (aa[n-1] == bb[n-1]) && (r[n-1] != aa[n-1]);
      return {r[n], ov, r[63:0] & m[63:0]};
   endfunction

   always @(negedge clk) begin
      if (rst || !sb_on) hold_prev = 1'b0;
      else begin
         if (hold_prev) chk("hold", {1'b0, out_valid, sum}, {1'b0, hold_val});
         if (in_valid && in_ready) q.push_back(model(64, x, y, sub, cin));
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", {65'd0, out_valid}, 66'd0);
            else chk("stream", {cout, ovf, sum}, q.pop_front());
         end
         hold_prev = out_valid && !out_ready;
         hold_val  = {out_valid, sum};
      end
   end

   always @(negedge clk) begin
      if (rst || !sb2_on) hold2_prev = 1'b0;
      else begin
         if (hold2_prev) chk("hold2", {33'd0, out_valid2, sum2}, {33'd0, hold2_val});
         if (in_valid2 && in_ready2) q2.push_back(model(32, {32'd0, x2}, {32'd0, y2}, sub2, cin2));
         if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) chk("unexpected_out2", {65'd0, out_valid2}, 66'd0);
            else chk("stream2", {cout2, ovf2, 32'd0, sum2}, q2.pop_front());
         end
         hold2_prev = out_valid2 && !out_ready2;
         hold2_val  = {out_valid2, sum2};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      tbl[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      tbl[2]  = '{64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      tbl[3]  = '{64'h5, 64'h3, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};
      tbl[4]  = '{64'h1, 64'h2, 1'b0, 1'b1, 64'h4, 1'b0, 1'b0};
      tbl[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
      tbl[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      tbl[7]  = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0};
      tbl[8]  = '{64'h1234, 64'h1234, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
      tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      tbl[10] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
      tbl[11] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0};
      rst = 1'b1;
      in_valid = 0; sub = 0; cin = 0; x = '0; y = '0; out_ready = 1;
      in_valid2 = 0; sub2 = 0; cin2 = 0; x2 = '0; y2 = '0; out_ready2 = 1;
      #12;
      chk("rst_flags", {62'd0, out_valid, cout, ovf, in_ready}, 66'b0001);
      chk("rst_sum", {2'b0, sum}, 66'd0);
      chk("rst2_flags", {62'd0, out_valid2, cout2, ovf2, in_ready2}, 66'b0001);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         in_valid = 1; x = tbl[i].x; y = tbl[i].y; sub = tbl[i].sub; cin = tbl[i].cin;
         @(posedge clk); #1;
         in_valid = 0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
         end
         chk($sformatf("lat%0d", i), 66'(lat), 66'd4);
         chk($sformatf("vec%0d", i), {cout, ovf, sum}, {tbl[i].co, tbl[i].ov, tbl[i].s});
      end

      @(posedge clk); #1;
      in_valid = 1; x = 64'h0123_4567_89AB_CDEF; y = 64'h1111_1111_1111_1111; sub = 0; cin = 0;
      out_ready = 0;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_flags", {62'd0, out_valid, in_ready, cout, ovf}, 66'b1000);
         chk("hold_sum", {2'b0, sum}, {2'b0, 64'h1234_5678_9ABC_DF00});
         @(posedge clk);
      end
      #1 out_ready = 1;
      @(posedge clk); #1;
      chk("hold_release", {65'd0, out_valid}, 66'd0);

      sb_on = 1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         in_valid = 1; sub = 1'($urandom); cin = 1'($urandom);
         x = {$urandom, $urandom}; y = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            1: begin x = '1; y = 64'($urandom_range(0, 1)); sub = 0; end
            2: begin y = x; sub = 1; end
            3: y = ~x;
            default: ;
         endcase
      end
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("stream_drain", 66'(q.size()), 66'd0);

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid = 1; sub = 1'($urandom); cin = 1'($urandom);
         x = {$urandom, $urandom}; y = {$urandom, $urandom};
         out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      @(negedge clk); #1;
      chk("bp_drain", 66'(q.size()), 66'd0);
      chk("bp_idle", {65'd0, out_valid}, 66'd0);

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1; sub = 0; cin = 0; x = {$urandom, $urandom}; y = {$urandom, $urandom};
      end
      @(posedge clk); #2;
      in_valid = 0; rst = 1;
      #1;
      chk("rst_mid_ov", {65'd0, out_valid}, 66'd0);
      chk("rst_mid_sum", {2'b0, sum}, 66'd0);
      q.delete();
      @(negedge clk);
      @(negedge clk) rst = 0;
      repeat (8) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_no_stale", {65'd0, out_valid}, 66'd0);
      sb_on = 0;

      @(posedge clk); #1;
      in_valid2 = 1; x2 = 32'hFFFF_FFFF; y2 = 32'h1; sub2 = 0; cin2 = 0;
      @(posedge clk); #1;
      in_valid2 = 0;
      chk("lat1_valid", {65'd0, out_valid2}, 66'd1);
      chk("lat1_ripple", {cout2, ovf2, 32'd0, sum2}, {1'b1, 1'b0, 64'd0});
      @(posedge clk); #1;
      sb2_on = 1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         in_valid2 = 1'($urandom); sub2 = 1'($urandom); cin2 = 1'($urandom);
         x2 = $urandom; y2 = $urandom;
         out_ready2 = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid2 = 0; out_ready2 = 1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("drain2", 66'(q2.size()), 66'd0);
      chk("idle2", {65'd0, out_valid2}, 66'd0);
      sb2_on = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
